risc_control_fsm: RTL and testbench
===================================

Name: risc_control_fsm

Overview:
- Multi-cycle control unit for the 32-bit RISC core. It drives the ALU's 5-bit AluSignal and consumes its 2-bit Flags.
- Sequences fetch/decode/execute/memory/writeback, and handshakes with instruction and data memories.
- Owns the architectural flags register (E, GT) and resolves branches.
- Sits between the memories/register file and the datapath muxes.

Parameters:
- OPC_W, 5, opcode width (Instr[31:27]).
- DEFAULT_ALU, 5'b01101, AluSignal value driven outside active execution (nop code).

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- Instr  input  32  instruction-memory read data, valid when InstrAck=1
- InstrReq  output  1  instruction fetch request
- InstrAck  input  1  instruction memory done
- IrWrite  output  1  latch Instr into instruction register (1-cycle pulse)
- AluSignal  output  5  ALU operation code
- AluSrcImm  output  1  ALU B operand = immediate (Instr[26] I-bit)
- AluFlags  input  2  ALU flags: [0]=equal, [1]=greater
- DataReq  output  1  data memory request
- DataWe  output  1  1=store, 0=load
- DataAck  input  1  data memory done
- RegWrite  output  1  register-file write enable (1-cycle pulse)
- WbSel  output  2  00=ALU result, 01=memory data, 10=PC+4
- RegDstRa  output  1  write destination forced to ra (r15)
- PcWrite  output  1  PC update enable (exactly one pulse per instruction)
- PcSel  output  2  00=PC+4, 01=branch target, 10=ra
- FlagE  output  1  architectural equal flag
- FlagGT  output  1  architectural greater flag

Behaviour:
- Reset (async, rst_n=0):
  - State is FETCH, FlagE=FlagGT=0, internal opcode register = 5'b01101.
  - All enables/requests are 0, AluSignal=DEFAULT_ALU, WbSel=PcSel=00.
  - Reset mid-transaction abandons it; no PcWrite/RegWrite is emitted.
- States: FETCH, DECODE, EXECUTE, MEM, WB (one-hot or 3-bit encoding).
- FETCH:
  - InstrReq=1 until InstrAck sampled 1.
  - On the ack cycle IrWrite=1 and the opcode/I-bit are latched from Instr; next state is DECODE.
  - InstrAck while InstrReq=0 is ignored.
- DECODE: opcode class resolved.
  - nop (01101): PcWrite=1, PcSel=00 -> FETCH.
  - All other opcodes -> EXECUTE.
- EXECUTE: AluSignal = latched opcode for codes 00000-01100; ld/st use 00000 (address add).
  - ALU ops (00000-00100, 00110-01100): -> WB.
  - cmp (00101): FlagE<=AluFlags[0], FlagGT<=AluFlags[1]; PcWrite=1, PcSel=00 -> FETCH. Flags change only here.
  - ld (01110) / st (01111): -> MEM.
  - beq (10000): PcWrite=1, PcSel=FlagE?01:00 -> FETCH.
  - bgt (10001): PcWrite=1, PcSel=FlagGT?01:00 -> FETCH.
  - b (10010): PcWrite=1, PcSel=01 -> FETCH.
  - call (10011): PcWrite=1, PcSel=01, RegWrite=1, WbSel=10, RegDstRa=1 -> FETCH.
  - ret (10100): PcWrite=1, PcSel=10 -> FETCH.
- MEM: AluSignal held, DataReq=1, DataWe=(st). Held until DataAck.
  - On ack, st: PcWrite=1, PcSel=00 -> FETCH.
  - On ack, ld: -> WB.
- WB: RegWrite=1, WbSel=01 for ld else 00, PcWrite=1, PcSel=00 -> FETCH.
- AluSrcImm = latched I-bit in EXECUTE/MEM/WB, else 0.
- AluSignal = DEFAULT_ALU in FETCH and DECODE.
- Minimum latency in cycles (acks same-cycle): nop 2; branch, cmp, call, ret 3; ALU 4; st 4; ld 5.
- Wait states: memory stalls extend FETCH/MEM only; outputs are held stable throughout.
- Illegal opcodes (>10100) without the feature: treated as nop.

Optional Feature:
- Macro HALT_ON_ILLEGAL_EN.
- When defined:
  - Adds HALT state and output port Illegal (1 bit).
  - An illegal opcode in DECODE goes to HALT: Illegal=1, no PcWrite, all requests 0.
  - HALT is left only by reset.
- When undefined: no Illegal port; illegal opcodes behave as nop.

Decomposition:
- Package risc_ctrl_pkg holds:
  - opcode constants (OP_ADD..OP_RET)
  - state enum
  - WbSel/PcSel encodings
  - DEFAULT_ALU
- One sub-module, risc_op_decode (combinational): opcode -> class flags (is_alu, is_cmp, is_ld, is_st, is_br, is_call, is_ret, is_nop, is_illegal).

Test Plan:
- Reset: hold rst_n=0 mid-MEM with DataReq=1 -> all outputs 0 immediately; FETCH with InstrReq=1 in the first cycle after release.
- add r1,r2,r3 (Instr=0x00000000 form, opcode 00000), InstrAck delayed 3 cycles -> IrWrite on ack; AluSignal=00000 in EXECUTE/WB; one RegWrite (WbSel=00) and one PcWrite (PcSel=00) in WB.
- cmp with AluFlags=2'b01, then beq -> FlagE=1, FlagGT=0; beq gives PcSel=01. Then cmp with AluFlags=2'b10, beq -> PcSel=00; bgt -> PcSel=01.
- ld with DataAck after 2 wait cycles -> DataReq=1/DataWe=0 held 3 cycles, AluSignal=00000, AluSrcImm=1; WB: RegWrite=1, WbSel=01. Also st -> DataWe=1, no RegWrite.
- call then ret -> call: RegWrite=1, WbSel=10, RegDstRa=1, PcSel=01. Ret: PcSel=10, no RegWrite.
- Opcode 11111 -> with HALT_ON_ILLEGAL_EN: Illegal=1, no further InstrReq. Without the macro: PcWrite with PcSel=00 after 2 cycles.

Source files
------------

// File: rtl/risc_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC control unit: opcodes, state codes,
// writeback/PC mux encodings and the ALU nop code.
package risc_ctrl_pkg;

   localparam int          OPC_W       = 5;
   localparam logic [4:0]  DEFAULT_ALU = 5'b01101;

   localparam logic [4:0]  OP_ADD      = 5'b00000;
   localparam logic [4:0]  OP_CMP      = 5'b00101;
   localparam logic [4:0]  OP_ALU_LAST = 5'b01100;
   localparam logic [4:0]  OP_NOP      = 5'b01101;
   localparam logic [4:0]  OP_LD       = 5'b01110;
   localparam logic [4:0]  OP_ST       = 5'b01111;
   localparam logic [4:0]  OP_BEQ      = 5'b10000;
   localparam logic [4:0]  OP_BGT      = 5'b10001;
   localparam logic [4:0]  OP_B        = 5'b10010;
   localparam logic [4:0]  OP_CALL     = 5'b10011;
   localparam logic [4:0]  OP_RET      = 5'b10100;

   localparam logic [2:0]  S_FETCH     = 3'd0;
   localparam logic [2:0]  S_DECODE    = 3'd1;
   localparam logic [2:0]  S_EXECUTE   = 3'd2;
   localparam logic [2:0]  S_MEM       = 3'd3;
   localparam logic [2:0]  S_WB        = 3'd4;
   localparam logic [2:0]  S_HALT      = 3'd5;

   localparam logic [1:0]  WB_ALU      = 2'b00;
   localparam logic [1:0]  WB_MEM      = 2'b01;
   localparam logic [1:0]  WB_PC4      = 2'b10;

   localparam logic [1:0]  PC_PLUS4    = 2'b00;
   localparam logic [1:0]  PC_BRANCH   = 2'b01;
   localparam logic [1:0]  PC_RA       = 2'b10;

endpackage

// File: rtl/risc_op_decode.sv
// Combinational opcode classifier: maps the latched opcode to one-hot-ish
// class flags used by the control FSM.
module risc_op_decode
   import risc_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] opc,
   output logic             is_alu,
   output logic             is_cmp,
   output logic             is_ld,
   output logic             is_st,
   output logic             is_br,
   output logic             is_call,
   output logic             is_ret,
   output logic             is_nop,
   output logic             is_illegal
);

   assign is_cmp     = (opc == OP_CMP);
   assign is_alu     = (opc <= OP_ALU_LAST) && !is_cmp;
   assign is_nop     = (opc == OP_NOP);
   assign is_ld      = (opc == OP_LD);
   assign is_st      = (opc == OP_ST);
   assign is_br      = (opc == OP_BEQ) || (opc == OP_BGT) || (opc == OP_B);
   assign is_call    = (opc == OP_CALL);
   assign is_ret     = (opc == OP_RET);
   assign is_illegal = (opc > OP_RET);

endmodule

// File: rtl/risc_control_fsm.sv
// Multi-cycle control FSM (fetch/decode/execute/mem/wb) with flags register and
// branch resolution. Optional HALT_ON_ILLEGAL_EN adds a HALT state and Illegal port.
module risc_control_fsm
   import risc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Instr,
   output logic        InstrReq,
   input  logic        InstrAck,
   output logic        IrWrite,
   output logic [4:0]  AluSignal,
   output logic        AluSrcImm,
   input  logic [1:0]  AluFlags,
   output logic        DataReq,
   output logic        DataWe,
   input  logic        DataAck,
   output logic        RegWrite,
   output logic [1:0]  WbSel,
   output logic        RegDstRa,
   output logic        PcWrite,
   output logic [1:0]  PcSel,
   output logic        FlagE,
   output logic        FlagGT,
`ifdef HALT_ON_ILLEGAL_EN
   output logic        Illegal,
`endif
   output logic [2:0]  state_dbg
);

   logic [2:0]       state, state_nxt;
   logic [OPC_W-1:0] opc_q;
   logic             ibit_q;
   logic             is_alu, is_cmp, is_ld, is_st, is_br, is_call, is_ret, is_nop, is_illegal;
   logic             nop_like;
   logic [4:0]       alu_code;
   logic             instr_unused;

   assign instr_unused = ^Instr[25:0];
   assign state_dbg    = state;

   risc_op_decode u_dec (
      .opc        (opc_q),
      .is_alu     (is_alu),
      .is_cmp     (is_cmp),
      .is_ld      (is_ld),
      .is_st      (is_st),
      .is_br      (is_br),
      .is_call    (is_call),
      .is_ret     (is_ret),
      .is_nop     (is_nop),
      .is_illegal (is_illegal)
   );

`ifdef HALT_ON_ILLEGAL_EN
   assign nop_like = is_nop;
`else
   assign nop_like = is_nop | is_illegal;
`endif

   // ld/st borrow the add code to form the address; control-flow ops leave the ALU idle.
   assign alu_code = (opc_q <= OP_ALU_LAST) ? opc_q :
                     (is_ld || is_st)       ? OP_ADD : DEFAULT_ALU;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_FETCH;
         opc_q  <= DEFAULT_ALU;
         ibit_q <= 1'b0;
         FlagE  <= 1'b0;
         FlagGT <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH && InstrAck) begin
            opc_q  <= Instr[31 -: OPC_W];
            ibit_q <= Instr[26];
         end
         if (state == S_EXECUTE && is_cmp) begin
            FlagE  <= AluFlags[0];
            FlagGT <= AluFlags[1];
         end
      end
   end

   // Handshake: a request stays high, with all other outputs stable, until the
   // matching ack is sampled high on a rising edge; acks without a request are ignored.
   always_comb begin
      state_nxt = state;
      InstrReq  = 1'b0;
      IrWrite   = 1'b0;
      AluSignal = DEFAULT_ALU;
      AluSrcImm = 1'b0;
      DataReq   = 1'b0;
      DataWe    = 1'b0;
      RegWrite  = 1'b0;
      WbSel     = WB_ALU;
      RegDstRa  = 1'b0;
      PcWrite   = 1'b0;
      PcSel     = PC_PLUS4;
`ifdef HALT_ON_ILLEGAL_EN
      Illegal   = 1'b0;
`endif
      case (state)
         S_FETCH: begin
            // Reset parks the FSM in FETCH; gate the request so nothing leaks out during reset.
            InstrReq = rst_n;
            IrWrite  = rst_n & InstrAck;
            if (InstrAck) state_nxt = S_DECODE;
         end
         S_DECODE: begin
`ifdef HALT_ON_ILLEGAL_EN
            if (is_illegal) state_nxt = S_HALT;
            else
`endif
            if (nop_like) begin
               PcWrite   = 1'b1;
               state_nxt = S_FETCH;
            end else begin
               state_nxt = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            AluSignal = alu_code;
            AluSrcImm = ibit_q;
            if (is_alu) begin
               state_nxt = S_WB;
            end else if (is_ld || is_st) begin
               state_nxt = S_MEM;
            end else begin
               PcWrite   = 1'b1;
               state_nxt = S_FETCH;
               if (is_br) begin
                  if (opc_q == OP_BEQ)      PcSel = FlagE  ? PC_BRANCH : PC_PLUS4;
                  else if (opc_q == OP_BGT) PcSel = FlagGT ? PC_BRANCH : PC_PLUS4;
                  else                      PcSel = PC_BRANCH;
               end else if (is_call) begin
                  PcSel    = PC_BRANCH;
                  RegWrite = 1'b1;
                  WbSel    = WB_PC4;
                  RegDstRa = 1'b1;
               end else if (is_ret) begin
                  PcSel = PC_RA;
               end
            end
         end
         S_MEM: begin
            AluSignal = alu_code;
            AluSrcImm = ibit_q;
            DataReq   = 1'b1;
            DataWe    = is_st;
            if (DataAck) begin
               if (is_st) begin
                  PcWrite   = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end
         end
         S_WB: begin
            AluSignal = alu_code;
            AluSrcImm = ibit_q;
            RegWrite  = 1'b1;
            WbSel     = is_ld ? WB_MEM : WB_ALU;
            PcWrite   = 1'b1;
            state_nxt = S_FETCH;
         end
`ifdef HALT_ON_ILLEGAL_EN
         S_HALT: begin
            Illegal = 1'b1;
         end
`endif
         default: state_nxt = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_risc_control_fsm.sv
// Randomized self-checking bench for risc_control_fsm against a per-instruction
// transaction model (latency, pulses, mux selects, flags).
module tb_risc_control_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] Instr;
   logic        InstrReq, InstrAck, IrWrite;
   logic [4:0]  AluSignal;
   logic        AluSrcImm;
   logic [1:0]  AluFlags;
   logic        DataReq, DataWe, DataAck;
   logic        RegWrite, RegDstRa, PcWrite;
   logic [1:0]  WbSel, PcSel;
   logic        FlagE, FlagGT;
   logic [2:0]  state_dbg;
`ifdef HALT_ON_ILLEGAL_EN
   logic        Illegal;
`endif

   int total = 0;
   int bad   = 0;
   logic [1:0] exp_q[$];
   logic model_e  = 1'b0;
   logic model_gt = 1'b0;

   // clock / reset
   always #5 clk = ~clk;

   risc_control_fsm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Instr     (Instr),
      .InstrReq  (InstrReq),
      .InstrAck  (InstrAck),
      .IrWrite   (IrWrite),
      .AluSignal (AluSignal),
      .AluSrcImm (AluSrcImm),
      .AluFlags  (AluFlags),
      .DataReq   (DataReq),
      .DataWe    (DataWe),
      .DataAck   (DataAck),
      .RegWrite  (RegWrite),
      .WbSel     (WbSel),
      .RegDstRa  (RegDstRa),
      .PcWrite   (PcWrite),
      .PcSel     (PcSel),
      .FlagE     (FlagE),
      .FlagGT    (FlagGT),
`ifdef HALT_ON_ILLEGAL_EN
      .Illegal   (Illegal),
`endif
      .state_dbg (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one instruction through the handshakes and compare its observed
   // transaction against what the instruction set rules say must happen.
   task automatic run_instr(input logic [4:0] opc, input logic ibit, input int fd,
                            input int md, input logic [1:0] fl);
      logic is_cmp, is_alu, is_ld, is_st, is_call, is_ret, legal, nopl, halt_exp;
      int   exp_lat, exp_rw, exp_dreq;
      logic [1:0] exp_pc, exp_wb, pc_seen, wb_seen;
      logic [4:0] exp_alu, alu_dec, alu_exec;
      logic imm_exec, rdra_seen, dwe_seen, done;
      int   cyc, fcnt, mcnt, ack_cyc, ir_n, rw_n, pw_n, dreq_n;

      is_cmp  = (opc == 5'd5);
      is_alu  = (opc <= 5'd12) && !is_cmp;
      is_ld   = (opc == 5'd14);
      is_st   = (opc == 5'd15);
      is_call = (opc == 5'd19);
      is_ret  = (opc == 5'd20);
      legal   = (opc <= 5'd20);
      nopl    = (opc == 5'd13) || !legal;
`ifdef HALT_ON_ILLEGAL_EN
      halt_exp = !legal;
`else
      halt_exp = 1'b0;
`endif
      if (nopl)               exp_lat = fd + 2;
      else if (is_alu)        exp_lat = fd + 4;
      else if (is_st)         exp_lat = fd + md + 4;
      else if (is_ld)         exp_lat = fd + md + 5;
      else                    exp_lat = fd + 3;
      exp_rw   = (is_alu || is_ld || is_call) ? 1 : 0;
      exp_wb   = is_ld ? 2'b01 : (is_call ? 2'b10 : 2'b00);
      exp_dreq = (is_ld || is_st) ? md + 1 : 0;
      exp_alu  = (opc <= 5'd12) ? opc : ((is_ld || is_st) ? 5'd0 : 5'd13);
      case (opc)
         5'd16:   exp_pc = model_e  ? 2'b01 : 2'b00;
         5'd17:   exp_pc = model_gt ? 2'b01 : 2'b00;
         5'd18:   exp_pc = 2'b01;
         5'd19:   exp_pc = 2'b01;
         5'd20:   exp_pc = 2'b10;
         default: exp_pc = 2'b00;
      endcase
      if (!halt_exp) exp_q.push_back(exp_pc);

      cyc = 0; fcnt = 0; mcnt = 0; ack_cyc = -1;
      ir_n = 0; rw_n = 0; pw_n = 0; dreq_n = 0;
      pc_seen = 2'b11; wb_seen = 2'b11; rdra_seen = 1'b0; dwe_seen = 1'b0;
      alu_dec = 5'h1f; alu_exec = 5'h1f; imm_exec = 1'bx; done = 1'b0;
      Instr = {opc, ibit, 26'($urandom)};
      while (!done && cyc < 60) begin
         @(negedge clk);
         InstrAck = InstrReq && (fcnt == fd) && (ack_cyc < 0);
         DataAck  = DataReq && (mcnt == md);
         AluFlags = fl;
         #1;
         if (InstrAck) ack_cyc = cyc;
         if (IrWrite) ir_n++;
         if (InstrReq && !InstrAck) fcnt++;
         if (ack_cyc >= 0 && cyc == ack_cyc + 1) alu_dec = AluSignal;
         if (ack_cyc >= 0 && cyc == ack_cyc + 2) begin
            alu_exec = AluSignal;
            imm_exec = AluSrcImm;
         end
         if (DataReq) begin
            dreq_n++;
            dwe_seen = DataWe;
            if (!DataAck) mcnt++;
         end
         if (RegWrite) begin
            rw_n++;
            wb_seen   = WbSel;
            rdra_seen = RegDstRa;
         end
         if (PcWrite) begin
            pw_n++;
            pc_seen = PcSel;
            done    = 1'b1;
         end
         cyc++;
         if (halt_exp && cyc == fd + 4) done = 1'b1;
      end
      @(posedge clk);
      #1;
      check("timeout", {31'd0, done}, 32'd1);
      if (halt_exp) begin
`ifdef HALT_ON_ILLEGAL_EN
         check("halt_illegal", {31'd0, Illegal}, 32'd1);
`endif
         check("halt_instrreq", {31'd0, InstrReq}, 32'd0);
         check("halt_pcwrite", pw_n, 0);
         check("halt_regwrite", rw_n, 0);
      end else begin
         check("latency", cyc, exp_lat);
         check("irwrite_cnt", ir_n, 1);
         check("pcwrite_cnt", pw_n, 1);
         if (exp_q.size() > 0) check("pcsel", {30'd0, pc_seen}, {30'd0, exp_q.pop_front()});
         check("regwrite_cnt", rw_n, exp_rw);
         if (exp_rw == 1) begin
            check("wbsel", {30'd0, wb_seen}, {30'd0, exp_wb});
            check("regdstra", {31'd0, rdra_seen}, {31'd0, is_call});
         end
         check("datareq_cycles", dreq_n, exp_dreq);
         if (is_ld || is_st) check("datawe", {31'd0, dwe_seen}, {31'd0, is_st});
         check("alu_decode", {27'd0, alu_dec}, 32'd13);
         if (!nopl) begin
            check("alu_exec", {27'd0, alu_exec}, {27'd0, exp_alu});
            check("alu_imm", {31'd0, imm_exec}, {31'd0, ibit});
         end
         if (is_cmp) begin
            model_e  = fl[0];
            model_gt = fl[1];
         end
         check("flag_e", {31'd0, FlagE}, {31'd0, model_e});
         check("flag_gt", {31'd0, FlagGT}, {31'd0, model_gt});
      end
   endtask

   task automatic check_all_idle(input string tag);
      check({tag, "_instrreq"}, {31'd0, InstrReq}, 32'd0);
      check({tag, "_irwrite"}, {31'd0, IrWrite}, 32'd0);
      check({tag, "_datareq"}, {31'd0, DataReq}, 32'd0);
      check({tag, "_datawe"}, {31'd0, DataWe}, 32'd0);
      check({tag, "_regwrite"}, {31'd0, RegWrite}, 32'd0);
      check({tag, "_pcwrite"}, {31'd0, PcWrite}, 32'd0);
      check({tag, "_wbsel"}, {30'd0, WbSel}, 32'd0);
      check({tag, "_pcsel"}, {30'd0, PcSel}, 32'd0);
      check({tag, "_alusig"}, {27'd0, AluSignal}, 32'd13);
      check({tag, "_flags"}, {30'd0, FlagGT, FlagE}, 32'd0);
   endtask

   // Start a load, abandon it with reset while DataReq is high.
   task automatic reset_mid_mem();
      int dcnt = 0;
      int guard = 0;
      Instr = {5'd14, 1'b1, 26'd0};
      while (dcnt < 2 && guard < 20) begin
         @(negedge clk);
         InstrAck = InstrReq;
         DataAck  = 1'b0;
         #1;
         if (DataReq) dcnt++;
         guard++;
      end
      check("reset_reached_mem", dcnt, 2);
      rst_n    = 1'b0;
      InstrAck = 1'b1;
      #1;
      check_all_idle("rst_async");
      repeat (2) @(posedge clk);
      #1;
      check_all_idle("rst_hold");
      model_e  = 1'b0;
      model_gt = 1'b0;
      @(negedge clk);
      InstrAck = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_instrreq", {31'd0, InstrReq}, 32'd1);
      check("rst_release_pcwrite", {31'd0, PcWrite}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; Instr = 32'd0; InstrAck = 1'b0; DataAck = 1'b0; AluFlags = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      check_all_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // directed sequence
      run_instr(5'd0,  1'b0, 3, 0, 2'b00);   // add, delayed fetch ack
      run_instr(5'd5,  1'b0, 0, 0, 2'b01);   // cmp -> E
      run_instr(5'd16, 1'b0, 0, 0, 2'b00);   // beq taken
      run_instr(5'd5,  1'b1, 1, 0, 2'b10);   // cmp -> GT
      run_instr(5'd16, 1'b0, 0, 0, 2'b11);   // beq not taken
      run_instr(5'd17, 1'b0, 0, 0, 2'b00);   // bgt taken
      run_instr(5'd14, 1'b1, 0, 2, 2'b00);   // ld with wait states
      run_instr(5'd15, 1'b1, 0, 1, 2'b00);   // st
      run_instr(5'd19, 1'b0, 0, 0, 2'b00);   // call
      run_instr(5'd20, 1'b0, 0, 0, 2'b00);   // ret
      run_instr(5'd13, 1'b0, 0, 0, 2'b00);   // nop
      run_instr(5'd18, 1'b0, 2, 0, 2'b00);   // b
`ifndef HALT_ON_ILLEGAL_EN
      run_instr(5'd31, 1'b0, 0, 0, 2'b00);   // illegal behaves as nop
`endif
      run_instr(5'd5,  1'b0, 0, 0, 2'b11);
      reset_mid_mem();

      for (int i = 0; i < 200; i++) begin
`ifdef HALT_ON_ILLEGAL_EN
         run_instr(5'($urandom_range(0, 20)), 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), 2'($urandom));
`else
         run_instr(5'($urandom_range(0, 31)), 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), 2'($urandom));
`endif
      end

`ifdef HALT_ON_ILLEGAL_EN
      run_instr(5'd31, 1'b0, 1, 0, 2'b00);
      repeat (3) @(posedge clk);
      #1;
      check("halt_sticky_illegal", {31'd0, Illegal}, 32'd1);
      check("halt_sticky_instrreq", {31'd0, InstrReq}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
